// File: rtl/frame_buffer.sv
// Dual-port pixel frame buffer: queued processor writes, clear sweep, 1-cycle VGA read port.
// Optional FRAMEBUFFER_AUTOCLEAR_EN: start a clear to colour 0 right after reset release.
module frame_buffer #(
  parameter int ColorBits = 3,
  parameter int screenX   = 50,
  parameter int screenY   = 50,
  parameter int FifoDepth = 4
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 wrValid,
  output logic                 wrReady,
  input  logic [8:0]           wrX,
  input  logic [7:0]           wrY,
  input  logic [ColorBits-1:0] wrColor,
  input  logic                 clearReq,
  input  logic [ColorBits-1:0] clearColor,
  output logic                 busy,
  output logic                 errOOR,
  input  logic [8:0]           XRead,
  input  logic [7:0]           YRead,
  output logic [ColorBits-1:0] readValueMemory
);
  localparam int N  = screenX * screenY;
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [8:0]           x;
    logic [7:0]           y;
    logic [ColorBits-1:0] color;
  } wr_req_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  wr_req_t              fifo [FifoDepth];
  wr_req_t              head;
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        cnt;
  logic                 push, pop, empty, clr_go, autoclr_pend;
  logic [AW-1:0]        clr_addr;
  logic [ColorBits-1:0] clr_color;
  logic [31:0]          wr_full, rd_full;
  logic                 wr_in, rd_in;
  logic                 mem_we;
  logic [AW-1:0]        mem_wa;
  logic [ColorBits-1:0] mem_wd;
  logic [ColorBits-1:0] mem [N];

`ifdef FRAMEBUFFER_AUTOCLEAR_EN
  always_ff @(posedge clock or negedge resetN)
    if (!resetN)     autoclr_pend <= 1'b1;
    else if (clr_go) autoclr_pend <= 1'b0;
`else
  assign autoclr_pend = 1'b0;
`endif

  assign empty   = (cnt == '0);
  assign wrReady = (cnt != CW'(FifoDepth));
  assign push    = wrValid && wrReady;
  assign busy    = (state_q == CLEAR);
  assign head    = fifo[rptr];

  // a pending clear (requested or automatic) takes priority over draining the queue
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    clr_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (autoclr_pend || clearReq) begin
          state_d = CLEAR;
          clr_go  = 1'b1;
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      CLEAR:   if (clr_addr == AW'(N - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      clr_addr  <= '0;
      clr_color <= '0;
    end else if (clr_go) begin
      clr_addr  <= '0;
      clr_color <= autoclr_pend ? '0 : clearColor;
    end else if (busy) begin
      clr_addr  <= clr_addr + AW'(1);
    end

  always_ff @(posedge clock)
    if (push) fifo[wptr] <= '{x: wrX, y: wrY, color: wrColor};

  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end

  // full-width address so wrapped coordinates can never alias a valid pixel
  assign wr_full = 32'(head.y) * 32'(screenX) + 32'(head.x);
  assign wr_in   = (32'(head.x) < 32'(screenX)) && (32'(head.y) < 32'(screenY))
                && (wr_full < 32'(N));
  assign rd_full = 32'(YRead) * 32'(screenX) + 32'(XRead);
  assign rd_in   = (32'(XRead) < 32'(screenX)) && (32'(YRead) < 32'(screenY))
                && (rd_full < 32'(N));

  always_ff @(posedge clock or negedge resetN)
    if (!resetN)            errOOR <= 1'b0;
    else if (pop && !wr_in) errOOR <= 1'b1;

  assign mem_we = busy || (pop && wr_in);
  assign mem_wa = busy ? clr_addr  : AW'(wr_full);
  assign mem_wd = busy ? clr_color : head.color;

  always_ff @(posedge clock)
    if (mem_we) mem[mem_wa] <= mem_wd;

  // registered read samples the pre-write contents on a same-address collision
  always_ff @(posedge clock or negedge resetN)
    if (!resetN)    readValueMemory <= '0;
    else if (rd_in) readValueMemory <= mem[AW'(rd_full)];
    else            readValueMemory <= '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: reads push expected colours, a negedge monitor pops/compares.
module tb_frame_buffer;
  localparam int SX = 50, SY = 50, N = SX * SY;

  logic       clock = 1'b0;
  logic       resetN, wrValid, wrReady, clearReq, busy, errOOR;
  logic [8:0] wrX, XRead;
  logic [7:0] wrY, YRead;
  logic [2:0] wrColor, clearColor, readValueMemory;

  frame_buffer dut (
    .clock(clock), .resetN(resetN), .wrValid(wrValid), .wrReady(wrReady),
    .wrX(wrX), .wrY(wrY), .wrColor(wrColor), .clearReq(clearReq),
    .clearColor(clearColor), .busy(busy), .errOOR(errOOR),
    .XRead(XRead), .YRead(YRead), .readValueMemory(readValueMemory)
  );

  always #5 clock = ~clock;

  int         total = 0, bad = 0;
  logic [2:0] model [N];
  logic [2:0] exp_q [$];
  string      tag_q [$];
  logic       rd_vld = 1'b0, rd_issued_q = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) rd_issued_q <= rd_vld;

  always @(negedge clock)
    if (rd_issued_q) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk(tag_q.pop_front(), 32'(readValueMemory), 32'(exp_q.pop_front()));
    end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [2:0] mexp(int x, int y);
    if (x < SX && y < SY) return model[y*SX + x];
    return 3'd0;
  endfunction

  task automatic fill(logic [2:0] c);
    for (int i = 0; i < N; i++) model[i] = c;
  endtask

  task automatic rd(int x, int y, string tag);
    XRead = 9'(x); YRead = 8'(y);
    exp_q.push_back(mexp(x, y));
    tag_q.push_back(tag);
    rd_vld = 1'b1;
    tick();
    rd_vld = 1'b0;
  endtask

  task automatic wr(int x, int y, int c);
    int n = 0;
    wrX = 9'(x); wrY = 8'(y); wrColor = 3'(c); wrValid = 1'b1;
    while (!wrReady && n < 100) begin tick(); n++; end
    if (n >= 100) chk("wr_timeout", 0, 1);
    tick();
    wrValid = 1'b0;
    if (x < SX && y < SY) model[y*SX + x] = 3'(c);
  endtask

  task automatic clr(logic [2:0] c);
    clearColor = c; clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 6000) begin tick(); n++; end
    if (n >= 6000) chk("idle_timeout", 0, 1);
    repeat (8) tick();
  endtask

  int wx [6] = '{1, 2, 1, 3, 1, 4};
  int wy [6] = '{1, 1, 1, 3, 1, 4};
  int wc [6] = '{2, 3, 4, 5, 6, 7};

  initial begin
    int  n, i;
    logic rdy, bz;
    resetN = 1'b1; wrValid = 1'b0; wrX = '0; wrY = '0; wrColor = '0;
    clearReq = 1'b0; clearColor = '0; XRead = '0; YRead = '0;
    #2 resetN = 1'b0;
    repeat (3) tick();
    chk("rst_rdval", 32'(readValueMemory), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(errOOR), 0);
    chk("rst_ready", 32'(wrReady), 1);
    resetN = 1'b1;
`ifdef FRAMEBUFFER_AUTOCLEAR_EN
    tick();
    chk("auto_busy", 32'(busy), 1);
    wait_idle();
`endif

    // clear to 0 and measure the sweep length
    clr(3'd0);
    n = 0;
    while (busy && n < 6000) begin n++; tick(); end
    chk("clr_len", n, N);
    fill(3'd0);
    rd(0, 0, "clr0_00"); rd(49, 49, "clr0_4949"); rd(25, 10, "clr0_2510");

    // single write, read two edges after acceptance
    wr(10, 20, 5);
    tick();
    rd(10, 20, "wr_1020"); rd(11, 20, "wr_1120");

    // queued writes during a clear to colour 1
    clr(3'd1);
    fill(3'd1);
    i = 0; n = 0;
    wrX = 9'(wx[0]); wrY = 8'(wy[0]); wrColor = 3'(wc[0]); wrValid = 1'b1;
    while (i < 6 && n < 6000) begin
      rdy = wrReady; bz = busy;
      tick(); n++;
      if (rdy) begin
        model[wy[i]*SX + wx[i]] = 3'(wc[i]);
        if (i == 4) chk("acc5_busy", 32'(bz), 0);
        i++;
        if (i == 4) begin
          chk("full_ready", 32'(wrReady), 0);
          chk("full_busy", 32'(busy), 1);
        end
        if (i < 6) begin wrX = 9'(wx[i]); wrY = 8'(wy[i]); wrColor = 3'(wc[i]); end
      end
    end
    wrValid = 1'b0;
    chk("q_accepted", i, 6);
    wait_idle();
    rd(1, 1, "q_11"); rd(2, 1, "q_21"); rd(3, 3, "q_33"); rd(4, 4, "q_44");
    rd(0, 0, "q_00"); rd(10, 20, "q_1020");
    chk("err_clean", 32'(errOOR), 0);

    // out-of-range writes and reads
    wr(50, 0, 7); wr(0, 50, 7);
    repeat (4) tick();
    chk("err_set", 32'(errOOR), 1);
    rd(0, 0, "oor_00"); rd(49, 0, "oor_490"); rd(0, 49, "oor_049"); rd(60, 0, "oor_rd60");

    // read-before-write on (5,5)
    wr(5, 5, 1);
    repeat (4) tick();
    wr(5, 5, 6);
    model[5*SX + 5] = 3'd1;
    rd(5, 5, "rbw_old");
    model[5*SX + 5] = 3'd6;
    rd(5, 5, "rbw_new");
    tick();

    // reset in the middle of a clear
    clr(3'd2);
    wr(7, 7, 3);
    repeat (97) tick();
    resetN = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rdval", 32'(readValueMemory), 0);
    chk("mid_ready", 32'(wrReady), 1);
    chk("mid_err", 32'(errOOR), 0);
    tick();
    resetN = 1'b1;
`ifdef FRAMEBUFFER_AUTOCLEAR_EN
    tick();
    chk("mid_auto_busy", 32'(busy), 1);
    wait_idle();
    fill(3'd0);
    rd(0, 0, "mid_auto_00");
`else
    repeat (5) tick();
    chk("mid_idle", 32'(busy), 0);
    chk("mid_ready2", 32'(wrReady), 1);
`endif
    tick();
    @(negedge clock);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
